// File: rtl/interpolator_intensity.sv
// Per-transducer intensity interpolator: moves each applied intensity toward its
// target by at most UPDATE_RATE per frame, with a 256-entry state RAM zeroed by an INIT sweep.
module interpolator_intensity #(
  parameter int DEPTH = 249
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN_VALID,
  input  logic [7:0] UPDATE_RATE,
  input  logic [7:0] INTENSITY,
  output logic       READY,
  output logic [7:0] INTENSITY_OUT,
  output logic       DOUT_VALID,
  output logic [7:0] DOUT_IDX
);

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_ready_next;
  logic       r_ready;
  logic [7:0] r_init_addr;
  logic [7:0] r_idx;
  logic [7:0] r_mem [0:255];

  logic       w_accept;
  logic       r_s1_valid;
  logic [7:0] r_s1_rate;
  logic [7:0] r_s1_tgt;
  logic [7:0] r_s1_cur;
  logic [7:0] r_s1_idx;

  logic [7:0] w_diff;
  logic [7:0] w_step;
  logic [7:0] w_new;

  logic       w_mem_we;
  logic [7:0] w_mem_addr;
  logic [7:0] w_mem_wdata;

  logic       r_dout_valid;
  logic [7:0] r_intensity_out;
  logic [7:0] r_dout_idx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_init_addr == 8'd255) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_INIT;
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  // READY is computed from the next state so it rises together with the RUN entry.
  always_comb begin
    w_ready_next = 1'b0;
    case (w_state_next)
      ST_RUN:  w_ready_next = 1'b1;
      ST_INIT: w_ready_next = 1'b0;
      default: w_ready_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ready     <= 1'b0;
      r_init_addr <= 8'd0;
    end else begin
      r_ready <= w_ready_next;
      if (r_state == ST_INIT) begin
        r_init_addr <= r_init_addr + 8'd1;
      end else begin
        r_init_addr <= 8'd0;
      end
    end
  end

  assign w_accept = DIN_VALID & r_ready;

  // Frame position is purely a count of accepted samples; gaps hold the index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx <= 8'd0;
    end else if (w_accept) begin
      if (r_idx == LAST_IDX) begin
        r_idx <= 8'd0;
      end else begin
        r_idx <= r_idx + 8'd1;
      end
    end else begin
      r_idx <= r_idx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1_valid <= 1'b0;
      r_s1_rate  <= 8'd0;
      r_s1_tgt   <= 8'd0;
      r_s1_cur   <= 8'd0;
      r_s1_idx   <= 8'd0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_rate <= UPDATE_RATE;
        r_s1_tgt  <= INTENSITY;
        r_s1_cur  <= r_mem[r_idx];
        r_s1_idx  <= r_idx;
      end else begin
        r_s1_rate <= r_s1_rate;
        r_s1_tgt  <= r_s1_tgt;
        r_s1_cur  <= r_s1_cur;
        r_s1_idx  <= r_s1_idx;
      end
    end
  end

  // Step is clamped to the remaining distance, so the sum/difference cannot wrap.
  always_comb begin
    w_diff = 8'd0;
    w_step = 8'd0;
    w_new  = r_s1_cur;
    if (r_s1_tgt > r_s1_cur) begin
      w_diff = r_s1_tgt - r_s1_cur;
      w_step = (r_s1_rate < w_diff) ? r_s1_rate : w_diff;
      w_new  = r_s1_cur + w_step;
    end else if (r_s1_tgt < r_s1_cur) begin
      w_diff = r_s1_cur - r_s1_tgt;
      w_step = (r_s1_rate < w_diff) ? r_s1_rate : w_diff;
      w_new  = r_s1_cur - w_step;
    end else begin
      w_new = r_s1_cur;
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = 8'd0;
    w_mem_wdata = 8'd0;
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_init_addr;
      w_mem_wdata = 8'd0;
    end else begin
      w_mem_we    = r_s1_valid;
      w_mem_addr  = r_s1_idx;
      w_mem_wdata = w_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout_valid    <= 1'b0;
      r_intensity_out <= 8'd0;
      r_dout_idx      <= 8'd0;
    end else begin
      r_dout_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_intensity_out <= w_new;
        r_dout_idx      <= r_s1_idx;
      end else begin
        r_intensity_out <= r_intensity_out;
        r_dout_idx      <= r_dout_idx;
      end
    end
  end

  assign READY         = r_ready;
  assign DOUT_VALID    = r_dout_valid;
  assign INTENSITY_OUT = r_intensity_out;
  assign DOUT_IDX      = r_dout_idx;

endmodule

// File: doc/interpolator_intensity.md
Name: interpolator_intensity

Overview:
- Downstream neighbour of the intensity step calculator in the silencer path.
- Consumes the per-transducer update rate stream with the matching target intensity stream.
- Keeps the current applied intensity for each of DEPTH transducers and moves it toward its target by at most UPDATE_RATE per frame, without overshoot.
- Emits the interpolated intensity stream, in transducer order, to the modulation/pulse-width stage.

Parameters:
- DEPTH, 249, number of transducers per frame; legal range 2..256.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- DIN_VALID  input  1  UPDATE_RATE/INTENSITY valid; one transducer per asserted cycle, in index order
- UPDATE_RATE  input  8  maximum intensity change this frame for the current transducer
- INTENSITY  input  8  target intensity for the current transducer
- READY  output  1  high once the state RAM is initialised; samples offered while low are dropped
- INTENSITY_OUT  output  8  interpolated intensity
- DOUT_VALID  output  1  INTENSITY_OUT valid
- DOUT_IDX  output  8  transducer index of INTENSITY_OUT

Behaviour:
- Interface (already decided): one clock domain (CLK); reset is asynchronous and active-low (RST_N).
- Reset values:
  - READY=0, DOUT_VALID=0, INTENSITY_OUT=0, DOUT_IDX=0.
  - Internal index counter=0; FSM enters INIT.
- State RAM: 256x8 current_mem. RST_N cannot clear it, so initialisation is done by the FSM.
- FSM:
  - INIT: writes 0 to current_mem[0..255] (address counter 0..255, one write per cycle), READY=0. After address 255 is written -> RUN. INIT lasts 256 cycles after RST_N deasserts.
  - RUN: READY=1. Stays in RUN until reset.
  - RST_N asserted in any state -> outputs to reset values immediately, pipeline flushed, INIT restarts on deassertion.
- Accept rule: a sample is accepted when DIN_VALID=1 and READY=1. DIN_VALID during INIT is ignored and the index does not advance.
- Index: idx starts at 0 and increments on each accepted sample; it wraps to 0 after DEPTH-1.
  - Gaps (DIN_VALID low mid-frame) hold idx; no timeout.
  - Frame boundary is defined only by the count of accepted samples.
- Pipeline, latency 2 cycles from accepted input to DOUT_VALID:
  - Stage 1: read current_mem[idx]; register UPDATE_RATE, INTENSITY, idx.
  - Stage 2: compute and register outputs; write the result back to current_mem[idx] in the same cycle.
- Arithmetic, 9-bit unsigned intermediates, no wrap:
  - target>cur: new = cur + min(rate, target-cur).
  - target<cur: new = cur - min(rate, cur-target).
  - target==cur or rate==0: new = cur.
  - The result never crosses the target and never leaves 0..255.
- Output: INTENSITY_OUT=new, DOUT_IDX=stage-2 idx, DOUT_VALID=1 for exactly one cycle per accepted sample.
- Hazard: DEPTH>=2 guarantees the same index is never read while its write-back is pending in back-to-back streaming. DEPTH=1 is illegal.
- Simultaneous accept and wrap: the sample at idx=DEPTH-1 is processed normally, and the next accepted sample uses idx 0.
- Throughput: one sample per cycle sustained; no backpressure.

Test Plan:
- Init: release RST_N; drive DIN_VALID=1 for 10 cycles during INIT -> READY rises exactly 256 cycles after deassertion, no DOUT_VALID pulses; first frame then ramps from 0 for every index.
- Ramp up: all targets 200, rate 50, 5 frames of 249 samples -> outputs 50,100,150,200,200 for every index; DOUT_VALID exactly 2 cycles after each input, DOUT_IDX 0..248 in order.
- Ramp down with clamp: from 200, target 30, rate 80 -> 120, 40, 30, 30 (no undershoot). Target 255 from 250, rate 255 -> 255 (no overflow).
- Per-index independence: idx 5 target 100 rate 100, all others target 0 -> only DOUT_IDX=5 outputs 100; all others 0. In the next frame, idx 5 rate 0 target 0 -> holds 100.
- Gapped stream: insert random 1-3 cycle DIN_VALID gaps mid-frame -> identical output sequence and indices to the gapless run; wrap to idx 0 after 249 accepted samples.
- Reset mid-frame: assert RST_N low at idx 120 -> DOUT_VALID drops immediately; after 256-cycle INIT the next frame restarts at idx 0 with all currents 0.
